// File: rtl/req_ack_pkg.sv
// Shared types and default sizing for the req/ack requester and its bench responder models.
// The optional timeout (macro REQ_INIT_TIMEOUT_EN) uses TIMEOUT_CYC_DEF.
package req_ack_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int CNT_W_DEF       = 8;
    localparam int GAP_CYCLES_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/req_ack_err_monitor.sv
// Sticky protocol-error flags: spurious ack while req is low, and timeout abort.
// A set event in the same cycle as err_clr wins over the clear.
module req_ack_err_monitor (
    input  logic clk,
    input  logic reset_n,
    input  logic i_req,
    input  logic i_ack,
    input  logic i_timeout,
    input  logic i_err_clr,
    output logic o_err_spur_ack,
    output logic o_err_timeout
);

    logic r_err_spur_ack;
    logic r_err_timeout;
    logic w_spur_evt;

    // i_req is the registered req, so an ack in the accepting IDLE cycle still counts.
    assign w_spur_evt = i_ack && !i_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err_spur_ack <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_err_spur_ack <= (r_err_spur_ack && !i_err_clr) || w_spur_evt;
            r_err_timeout  <= (r_err_timeout  && !i_err_clr) || i_timeout;
        end
    end

    assign o_err_spur_ack = r_err_spur_ack;
    assign o_err_timeout  = r_err_timeout;

endmodule

// File: rtl/req_ack_initiator.sv
// Requester end of a single-bit req/ack handshake: IDLE -> REQ -> GAP, all outputs registered.
// Optional req timeout abort when REQ_INIT_TIMEOUT_EN is defined.
module req_ack_initiator
    import req_ack_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] start_data,
    input  logic              err_clr,
    output logic              req,
    output logic [DATA_W-1:0] req_data,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  done_latency,
    output logic [CNT_W-1:0]  txn_count,
    output logic              err_spur_ack,
    output logic              err_timeout
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t              r_state;
    logic                r_req;
    logic [DATA_W-1:0]   r_req_data;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_done_latency;
    logic [CNT_W-1:0]    r_txn_count;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                w_timeout;

`ifdef REQ_INIT_TIMEOUT_EN
    // A same-cycle ack takes priority, so the abort is qualified by !ack.
    assign w_timeout = (r_state == ST_REQ) && !ack &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYC));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_req          <= 1'b0;
            r_req_data     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_done_latency <= '0;
            r_txn_count    <= '0;
            r_wait_cnt     <= '0;
            r_gap_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_req_data <= start_data;
                        r_req      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= CNT_W'(1);
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        r_req          <= 1'b0;
                        r_done         <= 1'b1;
                        r_done_latency <= r_wait_cnt;
                        r_txn_count    <= r_txn_count + 1'b1;
                        r_gap_cnt      <= GAP_W'(GAP_CYCLES - 1);
                        r_state        <= ST_GAP;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        r_state   <= ST_GAP;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    req_ack_err_monitor u_err_monitor (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_req          (r_req),
        .i_ack          (ack),
        .i_timeout      (w_timeout),
        .i_err_clr      (err_clr),
        .o_err_spur_ack (err_spur_ack),
        .o_err_timeout  (err_timeout)
    );

    assign req          = r_req;
    assign req_data     = r_req_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign done_latency = r_done_latency;
    assign txn_count    = r_txn_count;

endmodule

// File: tb/tb_req_ack_initiator.sv
// Bench for req_ack_initiator: fixed/random-latency ack responder plus a timestamp-based
// transaction reference model checked every cycle, and directed scenario checks.
module tb_req_ack_initiator;
    import req_ack_pkg::*;

    localparam int DW   = DATA_W_DEF;
    localparam int CW   = CNT_W_DEF;
    localparam int GAP  = GAP_CYCLES_DEF;
    localparam int TO   = TIMEOUT_CYC_DEF;
    localparam int MAXC = (1 << CW) - 1;
`ifdef REQ_INIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] start_data;
    logic          err_clr;
    logic          req;
    logic [DW-1:0] req_data;
    logic          ack;
    logic          busy;
    logic          done;
    logic [CW-1:0] done_latency;
    logic [CW-1:0] txn_count;
    logic          err_spur_ack;
    logic          err_timeout;

    always #5 clk = ~clk;

    req_ack_initiator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .start_data   (start_data),
        .err_clr      (err_clr),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .busy         (busy),
        .done         (done),
        .done_latency (done_latency),
        .txn_count    (txn_count),
        .err_spur_ack (err_spur_ack),
        .err_timeout  (err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each transaction is described by its accept edge and its end edge.
    int          m_cyc = 0;
    bit          m_act, m_end, m_end_ack, m_spur, m_to;
    int          m_rise, m_tend, m_lat, m_txn;
    logic [DW-1:0] m_data;

    always @(posedge clk) begin
        bit req_b, busy_b;
        int waited;
        #1;
        m_cyc++;
        if (!reset_n) begin
            m_act = 0; m_end = 0; m_end_ack = 0; m_spur = 0; m_to = 0;
            m_lat = 0; m_txn = 0; m_data = '0;
        end else begin
            req_b  = m_act && !m_end;
            busy_b = m_act;
            if (err_clr) begin m_spur = 0; m_to = 0; end
            if (ack && !req_b) m_spur = 1;
            if (!busy_b) begin
                if (start) begin
                    m_act = 1; m_end = 0; m_end_ack = 0;
                    m_rise = m_cyc; m_data = start_data;
                end
            end else if (!m_end) begin
                waited = (m_cyc - m_rise > MAXC) ? MAXC : m_cyc - m_rise;
                if (ack) begin
                    m_end = 1; m_end_ack = 1; m_tend = m_cyc;
                    m_lat = waited; m_txn = (m_txn + 1) % (MAXC + 1);
                end else if (TO_EN && waited == TO) begin
                    m_end = 1; m_tend = m_cyc; m_to = 1;
                end
            end else if (m_cyc - m_tend == GAP) begin
                m_act = 0;
            end
        end
        chk("m_req",      req,          m_act && !m_end);
        chk("m_busy",     busy,         m_act);
        chk("m_done",     done,         m_act && m_end_ack && m_cyc == m_tend);
        chk("m_req_data", req_data,     m_data);
        chk("m_latency",  done_latency, m_lat);
        chk("m_txn",      txn_count,    m_txn);
        chk("m_spur",     err_spur_ack, m_spur);
        chk("m_timeout",  err_timeout,  m_to);
    end

    // Responder: acks after r_lat req-high cycles (fixed or random), plus manual ack.
    bit resp_on = 0, resp_rand = 0, man_ack = 0;
    int fix_lat = 1, r_lat = 1, r_hi = 0;

    task automatic drive();
        if (req) r_hi++;
        else begin
            r_hi  = 0;
            r_lat = resp_rand ? int'($urandom_range(1, 8)) : fix_lat;
        end
        ack = man_ack || (resp_on && req && r_hi == r_lat);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin drive(); k++; end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        int hi, dn, lat, d_at, b_at, bad_dat, k, gap_lo, t0;
        reset_n = 0; start = 0; start_data = '0; err_clr = 0; ack = 0;
        @(negedge clk);
        repeat (3) drive();
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_spur", err_spur_ack, 0);
        reset_n = 1;
        drive();

        // Fixed latency 3 with payload A5
        resp_on = 1; resp_rand = 0; fix_lat = 3;
        start = 1; start_data = 8'hA5; drive(); start = 0;
        hi = 0; dn = 0; lat = 0; d_at = -1; b_at = -1; bad_dat = 0;
        for (int i = 0; i < 12; i++) begin
            if (req) begin hi++; if (req_data !== 8'hA5) bad_dat++; end
            if (done) begin dn++; lat = done_latency; d_at = i; end
            if (d_at >= 0 && !busy && b_at < 0) b_at = i;
            drive();
        end
        chk("t1_req_hi", hi, 3);
        chk("t1_data_bad", bad_dat, 0);
        chk("t1_dones", dn, 1);
        chk("t1_latency", lat, 3);
        chk("t1_txn", txn_count, 1);
        chk("t1_gap", b_at - d_at, GAP);

        // Ack in the first REQ cycle, then minimum gap before the next accept
        fix_lat = 1;
        start = 1; start_data = DW'($urandom); drive(); start = 0;
        k = 0;
        while (!done && k < 20) begin drive(); k++; end
        chk("t2_done_seen", done, 1);
        chk("t2_latency", done_latency, 1);
        start = 1; gap_lo = 0; k = 0;
        while (!req && k < 20) begin
            if (busy) gap_lo++;
            drive(); k++;
        end
        start = 0;
        chk("t2_gap_lo", gap_lo, GAP);
        wait_idle();

        // Start every cycle against the random-latency responder
        resp_rand = 1; t0 = txn_count; dn = 0;
        for (int i = 0; i < 50; i++) begin
            start = 1; start_data = DW'($urandom);
            if (done) dn++;
            drive();
        end
        start = 0; k = 0;
        while ((busy || done) && k < 50) begin
            if (done) dn++;
            drive(); k++;
        end
        chk("t3_dones_nz", dn > 3, 1);
        chk("t3_txn_vs_done", (txn_count - t0) & MAXC, dn & MAXC);
        chk("t3_spur", err_spur_ack, 0);
        chk("t3_timeout", err_timeout, 0);
        resp_rand = 0;

        // Spurious ack and clear priority
        man_ack = 1; drive(); man_ack = 0;
        chk("t4_spur_set", err_spur_ack, 1);
        chk("t4_busy", busy, 0);
        err_clr = 1; drive(); err_clr = 0;
        chk("t4_spur_clr", err_spur_ack, 0);
        err_clr = 1; man_ack = 1; drive(); err_clr = 0; man_ack = 0;
        chk("t4_set_wins", err_spur_ack, 1);
        err_clr = 1; drive(); err_clr = 0;
        chk("t4_spur_clr2", err_spur_ack, 0);

        // No ack: timeout abort, or indefinite wait without the timeout build
        resp_on = 0; t0 = txn_count;
        start = 1; drive(); start = 0;
        hi = 0; dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (req) hi++;
            if (done) dn++;
            drive();
        end
`ifdef REQ_INIT_TIMEOUT_EN
        chk("t5_req_hi", hi, TO);
        chk("t5_dones", dn, 0);
        chk("t5_err_to", err_timeout, 1);
        chk("t5_txn", txn_count, t0);
        err_clr = 1; drive(); err_clr = 0;
        wait_idle();
        resp_on = 1; fix_lat = TO;
        start = 1; drive(); start = 0;
        k = 0;
        while (!done && k < 60) begin drive(); k++; end
        chk("t5_ack_at_to_done", done, 1);
        chk("t5_ack_at_to_lat", done_latency, TO);
        chk("t5_ack_at_to_err", err_timeout, 0);
`else
        chk("t5_req_hi", hi, 40);
        chk("t5_still_req", req, 1);
        chk("t5_err_to", err_timeout, 0);
        man_ack = 1; drive(); man_ack = 0;
        chk("t5_late_done", done, 1);
        chk("t5_late_lat", done_latency, 41);
`endif
        wait_idle();

        // Reset while in REQ
        resp_on = 0;
        start = 1; drive(); start = 0;
        repeat (3) drive();
        reset_n = 0; drive(); reset_n = 1;
        chk("t6_req", req, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_txn", txn_count, 0);

        // 256 completions wrap the transaction counter
        resp_on = 1; fix_lat = 1; start = 1; dn = 0; k = 0;
        while (dn < MAXC + 1 && k < 3000) begin
            start_data = DW'($urandom);
            drive(); k++;
            if (done) dn++;
        end
        start = 0;
        chk("t6_wrap_dones", dn, MAXC + 1);
        chk("t6_wrap_txn", txn_count, 0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
